// File: rtl/cpe_pkg.sv
// Shared encodings for the core's memory-port arbiter: FSM states, owners,
// access-size codes and the default watchdog limit.
package cpe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_BUSY_IF = 2'b01,
    ST_BUSY_D  = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  localparam logic [1:0] BSEL_BYTE = 2'b00;
  localparam logic [1:0] BSEL_HALF = 2'b01;
  localparam logic [1:0] BSEL_WORD = 2'b10;

  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Watchdog counter for the arbiter. Counts busy cycles without ready and
// raises tc_o in the cycle whose increment would take the count to TIMEOUT-1.
module arb_timeout_ctr
  import cpe_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = 8'(TIMEOUT_DEF)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TC_VAL = TIMEOUT - 8'd2;

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = en_i && !clr_i && (cnt_q == TC_VAL);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// load/store. One transaction in flight; each completes with a registered
// one-cycle rvalid to its owner, or with rvalid+err when the watchdog fires.
module mem_port_arbiter
  import cpe_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk_w_i,
  input  logic              res_w_i_l,
  input  logic              if_req_w_i_h,
  input  logic [ADDR_W-1:0] if_addr_w_i,
  output logic              if_gnt_w_o_h,
  output logic              if_rvalid_w_o_h,
  output logic [DATA_W-1:0] if_rdata_w_o,
  input  logic              d_req_w_i_h,
  input  logic              d_wr_w_i_h,
  input  logic [ADDR_W-1:0] d_addr_w_i,
  input  logic [DATA_W-1:0] d_wdata_w_i,
  input  logic [1:0]        d_byte_sel_w_i,
  output logic              d_gnt_w_o_h,
  output logic              d_rvalid_w_o_h,
  output logic [DATA_W-1:0] d_rdata_w_o,
  output logic              mem_req_w_o_h,
  output logic              mem_wr_w_o_h,
  output logic [ADDR_W-1:0] mem_addr_w_o,
  output logic [DATA_W-1:0] mem_wdata_w_o,
  output logic [1:0]        mem_byte_sel_w_o,
  input  logic              mem_ready_w_i_h,
  input  logic [DATA_W-1:0] mem_rdata_w_i,
  output logic              err_w_o_h
);

  arb_state_e state_q, state_d;
  owner_e     last_owner_q, last_owner_d;

  logic              if_gnt, d_gnt;
  logic              busy, done, tc, timeout_hit;

  logic              mem_req_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [1:0]        mem_bsel_q;

  logic              if_rvalid_q, d_rvalid_q, err_q;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;

  assign busy        = (state_q != ST_IDLE);
  // Ready beats the watchdog when both land in the same cycle.
  assign timeout_hit = tc && !mem_ready_w_i_h;
  assign done        = busy && (mem_ready_w_i_h || tc);

  arb_timeout_ctr #(
    .TIMEOUT (8'(TIMEOUT))
  ) u_timeout_ctr (
    .clk_i  (clk_w_i),
    .rst_ni (res_w_i_l),
    .clr_i  (if_gnt || d_gnt),
    .en_i   (busy && !mem_ready_w_i_h),
    .tc_o   (tc)
  );

  // Next state, round-robin pick and combinational grants.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    if_gnt       = 1'b0;
    d_gnt        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Gated by reset so no grant is shown while the block is held in reset.
        if (res_w_i_l) begin
          if (if_req_w_i_h && (!d_req_w_i_h || last_owner_q == OWN_D)) begin
            if_gnt       = 1'b1;
            state_d      = ST_BUSY_IF;
            last_owner_d = OWN_IF;
          end else if (d_req_w_i_h) begin
            d_gnt        = 1'b1;
            state_d      = ST_BUSY_D;
            last_owner_d = OWN_D;
          end
        end
      end
      ST_BUSY_IF, ST_BUSY_D: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and arbitration history registers.
  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_D;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // Bus-side registers: loaded on grant, held while busy, cleared on completion.
  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bsel_q  <= '0;
    end else if (if_gnt) begin
      mem_req_q   <= 1'b1;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= if_addr_w_i;
      mem_wdata_q <= '0;
      mem_bsel_q  <= BSEL_WORD;
    end else if (d_gnt) begin
      mem_req_q   <= 1'b1;
      mem_wr_q    <= d_wr_w_i_h;
      mem_addr_q  <= d_addr_w_i;
      mem_wdata_q <= d_wdata_w_i;
      mem_bsel_q  <= d_byte_sel_w_i;
    end else if (done) begin
      mem_req_q   <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_bsel_q  <= '0;
    end
  end

  // Response pulses: rdata only for reads completed by ready, otherwise zero.
  always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
    if (!res_w_i_l) begin
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      if_rvalid_q <= done && (state_q == ST_BUSY_IF);
      d_rvalid_q  <= done && (state_q == ST_BUSY_D);
      if_rdata_q  <= (done && state_q == ST_BUSY_IF && mem_ready_w_i_h)
                     ? mem_rdata_w_i : '0;
      d_rdata_q   <= (done && state_q == ST_BUSY_D && mem_ready_w_i_h && !mem_wr_q)
                     ? mem_rdata_w_i : '0;
      err_q       <= timeout_hit;
    end
  end

  assign if_gnt_w_o_h     = if_gnt;
  assign d_gnt_w_o_h      = d_gnt;
  assign if_rvalid_w_o_h  = if_rvalid_q;
  assign if_rdata_w_o     = if_rdata_q;
  assign d_rvalid_w_o_h   = d_rvalid_q;
  assign d_rdata_w_o      = d_rdata_q;
  assign mem_req_w_o_h    = mem_req_q;
  assign mem_wr_w_o_h     = mem_wr_q;
  assign mem_addr_w_o     = mem_addr_q;
  assign mem_wdata_w_o    = mem_wdata_q;
  assign mem_byte_sel_w_o = mem_bsel_q;
  assign err_w_o_h        = err_q;

endmodule
